// File: rtl/bitrf_flush_ctrl.sv
// bitrf_flush_ctrl -- walks every set of a 4-way bit regfile, issuing a
// writeback for each set bit and clearing it afterwards. Pipeline bit updates
// always win the regfile port; the walk stalls around them.
//
// Optional feature: define BITRF_FLUSH_ABORT_EN to add the flush_abort input,
// which ends a walk early (from SCAN, or after a CLR write).
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   flush_start                one-cycle pulse, starts a walk when idle
//   upd_req/idx/way/val        pipeline bit update (always granted)
//   rd                         regfile read data for ra (combinational)
//   ra, wa, wr, in, way_sel    regfile read/write port
//   wb_req/idx/way, wb_ack     writeback handshake
//   busy, flush_done           walk in progress / completion pulse
//   wb_cnt                     writebacks issued in current/last flush
//   flush_abort                (BITRF_FLUSH_ABORT_EN only) abort the walk
module bitrf_flush_ctrl #(
  parameter int ENTRIES = 8192,
  parameter int IDX_W   = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_start,
  input  logic             upd_req,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [1:0]       upd_way,
  input  logic             upd_val,
  input  logic [3:0]       rd,
`ifdef BITRF_FLUSH_ABORT_EN
  input  logic             flush_abort,
`endif
  output logic [IDX_W-1:0] ra,
  output logic [IDX_W-1:0] wa,
  output logic             wr,
  output logic             in,
  output logic [3:0]       way_sel,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_idx,
  output logic [1:0]       wb_way,
  input  logic             wb_ack,
  output logic             busy,
  output logic             flush_done,
  output logic [15:0]      wb_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  logic [2:0]       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [3:0]       vec, vec_n;
  logic             stale, stale_n;
  logic [15:0]      cnt_n;
  logic             abort;
  logic [3:0]       clr_mask;

`ifdef BITRF_FLUSH_ABORT_EN
  assign abort = flush_abort;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [1:0] low_way(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign wb_way     = low_way(vec);
  assign wb_idx     = idx;
  assign wb_req     = (state == S_WB);
  assign busy       = (state != S_IDLE);
  assign flush_done = (state == S_DONE);
  assign clr_mask   = 4'b0001 << wb_way;

  // Regfile port: update first, then the walk's CLR write, else plain read.
  always_comb begin
    ra      = idx;
    wa      = idx;
    wr      = 1'b0;
    in      = 1'b0;
    way_sel = 4'b0000;
    if (upd_req) begin
      ra      = upd_idx;
      wa      = upd_idx;
      wr      = 1'b1;
      in      = upd_val;
      way_sel = 4'b0001 << upd_way;
    end else if (state == S_CLR) begin
      wr      = 1'b1;
      way_sel = clr_mask;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    vec_n   = vec;
    stale_n = stale;
    cnt_n   = wb_cnt;
    // An update hitting the set under writeback means vec no longer matches
    // the array; force a re-read of this set once the current bit is cleared.
    if (upd_req && (state == S_WB || state == S_CLR) && upd_idx == idx)
      stale_n = 1'b1;
    case (state)
      S_IDLE: begin
        if (flush_start) begin
          state_n = S_SCAN;
          idx_n   = '0;
          vec_n   = '0;
          stale_n = 1'b0;
          cnt_n   = '0;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_n = S_DONE;
        end else if (!upd_req) begin
          vec_n = rd;
          if (rd != 4'b0000)   state_n = S_WB;
          else if (idx == LAST) state_n = S_DONE;
          else                  idx_n   = idx + 1'b1;
        end
      end
      S_WB: begin
        // Abort is deliberately not looked at here: the handshake finishes.
        if (wb_ack) begin
          state_n = S_CLR;
          cnt_n   = (wb_cnt == 16'hFFFF) ? wb_cnt : wb_cnt + 16'd1;
        end
      end
      S_CLR: begin
        if (!upd_req) begin
          vec_n = vec & ~clr_mask;
          if (abort) begin
            state_n = S_DONE;
          end else if (stale) begin
            state_n = S_SCAN;
            stale_n = 1'b0;
          end else if (vec_n != 4'b0000) begin
            state_n = S_WB;
          end else if (idx == LAST) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SCAN;
            idx_n   = idx + 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      vec    <= '0;
      stale  <= 1'b0;
      wb_cnt <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      vec    <= vec_n;
      stale  <= stale_n;
      wb_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bitrf_flush_ctrl.sv
// Self-checking bench for bitrf_flush_ctrl: a behavioural bit regfile feeds
// rd and absorbs writes; expected writebacks are queued as the array is
// preloaded and popped when the DUT raises wb_req.
module tb_bitrf_flush_ctrl;
  localparam int ENTRIES = 8192;
  localparam int IDX_W   = 13;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush_start = 1'b0;
  logic             upd_req = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic [1:0]       upd_way = '0;
  logic             upd_val = 1'b0;
  logic [3:0]       rd;
  logic             flush_abort = 1'b0;
  logic [IDX_W-1:0] ra, wa, wb_idx;
  logic             wr, in, wb_req, busy, flush_done;
  logic             wb_ack = 1'b0;
  logic [3:0]       way_sel;
  logic [1:0]       wb_way;
  logic [15:0]      wb_cnt;

  bitrf_flush_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush_start(flush_start),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_way(upd_way), .upd_val(upd_val),
    .rd(rd),
`ifdef BITRF_FLUSH_ABORT_EN
    .flush_abort(flush_abort),
`endif
    .ra(ra), .wa(wa), .wr(wr), .in(in), .way_sel(way_sel),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_way(wb_way), .wb_ack(wb_ack),
    .busy(busy), .flush_done(flush_done), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [ENTRIES];
  assign rd = mem[ra];
  always @(posedge clk)
    if (wr)
      for (int w = 0; w < 4; w++)
        if (way_sel[w]) mem[wa][w] = in;

  int checks = 0;
  int fails  = 0;
  logic [IDX_W+1:0] exp_q[$];
  logic [IDX_W-1:0] last_idx;
  logic [1:0]       last_way;
  int               ack_delay = 0;
  bit               saw_wb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < ENTRIES; i++) mem[i] = 4'b0000;
    exp_q.delete();
    saw_wb = 1'b0;
  endtask

  function automatic int nonzero_sets();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) if (mem[i] != 4'b0000) n++;
    return n;
  endfunction

  task automatic push_exp(input int i, input int w);
    exp_q.push_back({IDX_W'(i), 2'(w)});
  endtask

  task automatic take_wb();
    logic [IDX_W+1:0] e;
    if (exp_q.size() == 0) begin
      chk("wb_unexpected", 32'({wb_idx, wb_way}), 32'h7FFFFFFF);
    end else begin
      e = exp_q.pop_front();
      chk("wb_idx", 32'(wb_idx), 32'(e[IDX_W+1:2]));
      chk("wb_way", 32'(wb_way), 32'(e[1:0]));
    end
    last_idx = wb_idx;
    last_way = wb_way;
  endtask

  task automatic start_flush();
    @(negedge clk);
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ra0", 32'(ra), 0);
  endtask

  // Runs from the current negedge until flush_done; returns cycles advanced.
  task automatic walk(input int poke, output int n);
    bit pending = 0;
    int hold = 0;
    n = 0;
    while (!flush_done && n < 20000) begin
      if (n == poke) flush_start = 1'b1;
      if (wr && !upd_req) begin
        chk("clr_wa", 32'(wa), 32'(last_idx));
        chk("clr_in", 32'(in), 0);
        chk("clr_sel", 32'(way_sel), 32'(4'b0001 << last_way));
      end
      if (wb_req) begin
        saw_wb = 1'b1;
        if (!pending) begin
          take_wb();
          pending = 1;
          hold = 0;
        end else begin
          chk("wb_hold", 32'({wb_idx, wb_way}), 32'({last_idx, last_way}));
        end
        if (hold == ack_delay) begin
          wb_ack = 1'b1;
          pending = 0;
        end else hold++;
      end
      @(negedge clk);
      wb_ack = 1'b0;
      flush_start = 1'b0;
      n++;
    end
    chk("walk_done", 32'(flush_done), 1);
    chk("q_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
    chk("done_pulse", 32'(flush_done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic wait_ra(input int target);
    int k = 0;
    while (ra != IDX_W'(target) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ra", 32'(ra), 32'(target));
  endtask

  task automatic wait_wb();
    int k = 0;
    while (!wb_req && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_wb", 32'(wb_req), 1);
  endtask

  initial begin
    int n;
    clear_mem();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(flush_done), 0);
    chk("rst_wbreq", 32'(wb_req), 0);
    chk("rst_cnt", 32'(wb_cnt), 0);
    chk("rst_wr", 32'(wr), 0);
    reset_n = 1'b1;

    // All-zero array: ENTRIES+1 cycles, a second flush_start mid-walk ignored.
    start_flush();
    walk(100, n);
    chk("done_cycle", 32'(n + 1), ENTRIES + 1);
    chk("t1_no_wb", 32'(saw_wb), 0);
    chk("t1_cnt", 32'(wb_cnt), 0);

    // Two ways in one set.
    clear_mem();
    mem[5] = 4'b1010;
    push_exp(5, 1);
    push_exp(5, 3);
    start_flush();
    walk(-1, n);
    chk("t2_cnt", 32'(wb_cnt), 2);
    chk("t2_clean", 32'(nonzero_sets()), 0);

    // First and last set, with a held writeback request.
    clear_mem();
    mem[0] = 4'b1000;
    mem[ENTRIES-1] = 4'b0001;
    push_exp(0, 3);
    push_exp(ENTRIES - 1, 0);
    ack_delay = 2;
    start_flush();
    walk(-1, n);
    ack_delay = 0;
    chk("t3_cnt", 32'(wb_cnt), 2);
    chk("t3_clean", 32'(nonzero_sets()), 0);

    // Three update cycles stall SCAN at idx 100; set 100 must still be seen.
    clear_mem();
    mem[100] = 4'b0001;
    push_exp(100, 0);
    push_exp(3000, 2);
    start_flush();
    wait_ra(100);
    upd_req = 1'b1; upd_idx = 13'd3000; upd_way = 2'd1; upd_val = 1'b1;
    #1;
    chk("upd_ra", 32'(ra), 3000);
    chk("upd_wa", 32'(wa), 3000);
    chk("upd_wr", 32'(wr), 1);
    chk("upd_sel1", 32'(way_sel), 32'h2);
    chk("upd_in", 32'(in), 1);
    @(negedge clk);
    upd_way = 2'd2;
    #1;
    chk("upd_ra2", 32'(ra), 3000);
    chk("upd_sel2", 32'(way_sel), 32'h4);
    @(negedge clk);
    upd_way = 2'd1; upd_val = 1'b0;
    #1;
    chk("upd_ra3", 32'(ra), 3000);
    chk("upd_in3", 32'(in), 0);
    @(negedge clk);
    upd_req = 1'b0;
    #1;
    chk("resume_ra", 32'(ra), 100);
    walk(-1, n);
    chk("t4_cnt", 32'(wb_cnt), 2);
    chk("t4_clean", 32'(nonzero_sets()), 0);

    // Update to the set under writeback forces a re-scan of that set.
    clear_mem();
    mem[7] = 4'b0001;
    push_exp(7, 0);
    push_exp(7, 2);
    start_flush();
    wait_wb();
    take_wb();
    upd_req = 1'b1; upd_idx = 13'd7; upd_way = 2'd2; upd_val = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    chk("stale_wb_held", 32'(wb_req), 1);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("stale_clr_wr", 32'(wr), 1);
    chk("stale_clr_wa", 32'(wa), 7);
    chk("stale_clr_sel", 32'(way_sel), 32'h1);
    walk(-1, n);
    chk("t5_cnt", 32'(wb_cnt), 2);
    chk("t5_clean", 32'(nonzero_sets()), 0);

    // Reset while wb_req is up: outputs drop at once, no CLR write.
    clear_mem();
    mem[3] = 4'b0001;
    mem[20] = 4'b0010;
    start_flush();
    begin
      int k = 0;
      while (!(wb_req && wb_idx == 13'd20) && k < 1000) begin
        wb_ack = wb_req;
        @(negedge clk);
        wb_ack = 1'b0;
        k++;
      end
    end
    chk("t6_at20", 32'(wb_req), 1);
    chk("t6_cnt_pre", 32'(wb_cnt), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wbreq", 32'(wb_req), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cnt", 32'(wb_cnt), 0);
    chk("t6_rst_wr", 32'(wr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_mem20", 32'(mem[20]), 32'h2);
    push_exp(20, 1);
    start_flush();
    walk(-1, n);
    chk("t6_cnt", 32'(wb_cnt), 1);

`ifdef BITRF_FLUSH_ABORT_EN
    clear_mem();
    mem[60] = 4'b0001;
    start_flush();
    wait_ra(50);
    flush_abort = 1'b1;
    @(negedge clk);
    flush_abort = 1'b0;
    chk("abort_done", 32'(flush_done), 1);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_mem60", 32'(mem[60]), 1);
    chk("abort_cnt", 32'(wb_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
